// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, types and GF(2^8) helpers.
// The S-box is stored as one packed constant, entry 0 in the top byte.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;
  localparam int RK_W = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef logic [RK_W-1:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } ks_state_t;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store.
// Optional macro AES_KEY_FLAT_OUT_EN adds the flattened round_keys_flat output.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key,
  output logic             busy,
  output logic             keys_valid,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [127:0]     rk_out
`ifdef AES_KEY_FLAT_OUT_EN
  ,
  output logic [(NR+1)*128-1:0] round_keys_flat
`endif
);

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("aes_key_sched_ctrl supports only NR=10 (AES-128)");
  end

  localparam logic [3:0] LAST_CTR = 4'(NR);

  ks_state_t  state, state_next;
  logic [3:0] ctr;
  logic [7:0] rcon;
  round_key_t work;
  round_key_t rk_mem [0:NR];

  logic [31:0] rot_w3, sub_w3, t_word;
  logic [31:0] w0n, w1n, w2n, w3n;
  round_key_t  next_key;
  logic        start_ok;

  // start is only honoured outside EXPAND; a mid-expansion pulse is dropped.
  assign start_ok = start && (state != EXPAND);

  assign rot_w3 = {work[23:0], work[31:24]};

  aes_subword u_subword (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign t_word   = sub_w3 ^ {rcon, 24'h0};
  assign w0n      = work[127:96] ^ t_word;
  assign w1n      = work[95:64]  ^ w0n;
  assign w2n      = work[63:32]  ^ w1n;
  assign w3n      = work[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, READY: if (start) state_next = EXPAND;
      EXPAND:      if (ctr == LAST_CTR) state_next = READY;
      default:     state_next = IDLE;
    endcase
  end

  assign busy       = (state == EXPAND);
  assign keys_valid = (state == READY);

  // Counter saturates at the last round so it can never index past the store.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr  <= '0;
      rcon <= RCON_INIT;
      work <= '0;
    end else if (start_ok) begin
      ctr  <= 4'd1;
      rcon <= RCON_INIT;
      work <= key;
    end else if (state == EXPAND) begin
      ctr  <= (ctr == LAST_CTR) ? ctr : ctr + 4'd1;
      rcon <= xtime(rcon);
      work <= next_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (start_ok)                rk_mem[0]   <= key;
      else if (state == EXPAND)    rk_mem[ctr] <= next_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         rk_out <= '0;
    else if (rk_idx <= IDX_W'(NR))   rk_out <= rk_mem[rk_idx];
    else                             rk_out <= '0;
  end

`ifdef AES_KEY_FLAT_OUT_EN
  always_comb begin
    round_keys_flat = '0;
    if (keys_valid) begin
      for (int i = 0; i <= NR; i++) round_keys_flat[i*128 +: 128] = rk_mem[i];
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl against an arithmetic FIPS-197 model.
// Build with AES_KEY_FLAT_OUT_EN defined to also exercise round_keys_flat.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef AES_KEY_FLAT_OUT_EN
  logic [1407:0] round_keys_flat;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] model_rk [0:10];

  localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
`ifdef AES_KEY_FLAT_OUT_EN
    ,
    .round_keys_flat (round_keys_flat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference arithmetic: GF(2^8) multiply, inverse and the S-box affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = ginv(8'(i));
      sbox_tab[i] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
               sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    step();
    start = 1'b0;
    key   = rand_key();
  endtask

  // Pulses start, then waits (bounded) for keys_valid, counting busy samples.
  task automatic run_expansion(input logic [127:0] k, output int busy_n,
                               output int lat, output logic kv_at_start);
    do_start(k);
    kv_at_start = keys_valid;
    busy_n = busy ? 1 : 0;
    lat = 0;
    while (!keys_valid && lat < 40) begin
      step();
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    rk_idx = 4'(idx);
    step();
    v = rk_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0; rk_idx = 4'd15;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_keys_valid: got %b expected 0", keys_valid); end
    checks++; if (rk_out !== 128'h0) begin errors++; $display("[TB] FAIL reset_rk_out: got %h expected 0", rk_out); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fips_a1();
    int busy_n, lat;
    logic kv0;
    logic [127:0] v;
    model_expand(KEY_A1);
    run_expansion(KEY_A1, busy_n, lat, kv0);
    checks++; if (busy_n != 10) begin errors++; $display("[TB] FAIL a1_busy_cycles: got %0d expected 10", busy_n); end
    checks++; if (lat != 10) begin errors++; $display("[TB] FAIL a1_valid_latency: got %0d expected 10", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL a1_busy_done: got %b expected 0", busy); end
    read_rk(1, v);
    checks++; if (v !== A1_RK1) begin errors++; $display("[TB] FAIL a1_rk1: got %h expected %h", v, A1_RK1); end
    read_rk(10, v);
    checks++; if (v !== A1_RK10) begin errors++; $display("[TB] FAIL a1_rk10: got %h expected %h", v, A1_RK10); end
    for (int i = 0; i < 11; i++) begin
      read_rk(i, v);
      checks++; if (v !== model_rk[i]) begin errors++; $display("[TB] FAIL a1_rk%0d: got %h expected %h", i, v, model_rk[i]); end
    end
  endtask

  task automatic test_restart_zero();
    int busy_n, lat;
    logic kv0;
    logic [127:0] v;
    model_expand(128'h0);
    run_expansion(128'h0, busy_n, lat, kv0);
    checks++; if (kv0 !== 1'b0) begin errors++; $display("[TB] FAIL restart_kv_drop: got %b expected 0", kv0); end
    checks++; if (lat != 10) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 10", lat); end
    read_rk(1, v);
    checks++; if (v !== ZERO_RK1) begin errors++; $display("[TB] FAIL zero_rk1: got %h expected %h", v, ZERO_RK1); end
    read_rk(10, v);
    checks++; if (v !== ZERO_RK10) begin errors++; $display("[TB] FAIL zero_rk10: got %h expected %h", v, ZERO_RK10); end
    read_rk(0, v);
    checks++; if (v !== 128'h0) begin errors++; $display("[TB] FAIL zero_rk0: got %h expected 0", v); end
    read_rk(11, v);
    checks++; if (v !== 128'h0) begin errors++; $display("[TB] FAIL idx11: got %h expected 0", v); end
    read_rk(15, v);
    checks++; if (v !== 128'h0) begin errors++; $display("[TB] FAIL idx15: got %h expected 0", v); end
  endtask

  task automatic test_start_ignored();
    logic [127:0] k1, v;
    int n;
    k1 = rand_key();
    model_expand(k1);
    do_start(k1);
    step(); step(); step();
    start = 1'b1;
    key   = rand_key();
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ignore_busy: got %b expected 1", busy); end
    n = 4;
    while (!keys_valid && n < 40) begin step(); n++; end
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 10", n); end
    for (int i = 0; i < 11; i++) begin
      read_rk(i, v);
      checks++; if (v !== model_rk[i]) begin errors++; $display("[TB] FAIL ignore_rk%0d: got %h expected %h", i, v, model_rk[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k2, v;
    int busy_n, lat;
    logic kv0;
    rk_idx = 4'd3;
    do_start(rand_key());
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_kv: got %b expected 0", keys_valid); end
    checks++; if (rk_out !== 128'h0) begin errors++; $display("[TB] FAIL midrst_rk_out: got %h expected 0", rk_out); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got %b expected 0", busy); end
    k2 = rand_key();
    model_expand(k2);
    run_expansion(k2, busy_n, lat, kv0);
    checks++; if (lat != 10) begin errors++; $display("[TB] FAIL midrst_relatency: got %0d expected 10", lat); end
    read_rk(10, v);
    checks++; if (v !== model_rk[10]) begin errors++; $display("[TB] FAIL midrst_rk10: got %h expected %h", v, model_rk[10]); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; start = 1'b1; key = rand_key();
    step();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstprio_busy: got %b expected 0", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstprio_busy2: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    logic [127:0] k, v;
    int busy_n, lat, idx;
    logic kv0;
    for (int t = 0; t < 4; t++) begin
      k = rand_key();
      model_expand(k);
      run_expansion(k, busy_n, lat, kv0);
      checks++; if (busy_n != 10) begin errors++; $display("[TB] FAIL rand_busy_cycles: got %0d expected 10", busy_n); end
      for (int j = 0; j < 6; j++) begin
        idx = $urandom_range(0, 15);
        read_rk(idx, v);
        checks++;
        if (v !== ((idx <= 10) ? model_rk[idx] : 128'h0)) begin
          errors++;
          $display("[TB] FAIL rand_rk%0d: got %h expected %h", idx, v, (idx <= 10) ? model_rk[idx] : 128'h0);
        end
      end
    end
  endtask

  task automatic test_flat_out();
`ifdef AES_KEY_FLAT_OUT_EN
    logic [127:0] k;
    int n;
    k = rand_key();
    model_expand(k);
    do_start(k);
    n = 0;
    while (!keys_valid && n < 40) begin
      checks++; if (round_keys_flat !== '0) begin errors++; $display("[TB] FAIL flat_busy_zero: got nonzero bus expected 0"); end
      step();
      n++;
    end
    checks++; if (round_keys_flat[127:0] !== k) begin errors++; $display("[TB] FAIL flat_rk0: got %h expected %h", round_keys_flat[127:0], k); end
    checks++; if (round_keys_flat[1407:1280] !== model_rk[10]) begin errors++; $display("[TB] FAIL flat_rk10: got %h expected %h", round_keys_flat[1407:1280], model_rk[10]); end
    for (int i = 1; i < 10; i++) begin
      checks++; if (round_keys_flat[i*128 +: 128] !== model_rk[i]) begin errors++; $display("[TB] FAIL flat_rk%0d: got %h expected %h", i, round_keys_flat[i*128 +: 128], model_rk[i]); end
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; rk_idx = '0;
    build_sbox();
    test_reset();
    test_fips_a1();
    test_restart_zero();
    test_start_ignored();
    test_reset_mid();
    test_reset_priority();
    test_random();
    test_flat_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
